// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between the writeback stage
// (wb_*) and the load-return/debug path (mem_*). Writeback has fixed priority. A
// starvation guard hands priority to mem after MAX_WAIT stalled cycles.
// The granted write is registered onto rf_we/rf_rd/rf_wdata one cycle later.
// Writes to x0 are accepted and then dropped.
// Optional feature macro: RFARB_STATS_EN adds the saturating conflict_cnt output.
module rf_write_arbiter #(
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mem_pri
`ifdef RFARB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned STAT_W = 16;

    typedef enum logic {
        WB_PRI  = 1'b0,
        MEM_PRI = 1'b1
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    wait_q;
    logic [CNT_W-1:0]    wait_inc;
    logic                mem_stall;
    logic                flip;
    logic                wb_hs;
    logic                mem_hs;
    logic                hs;
    logic [ADDR_W-1:0]   sel_rd;
    logic [DATA_W-1:0]   sel_data;
    logic                rf_we_q;
    logic [ADDR_W-1:0]   rf_rd_q;
    logic [DATA_W-1:0]   rf_wdata_q;

    // Readies are held low during reset so a request seen then stays pending.
    assign wb_ready  = !reset && !freeze && ((state_q == WB_PRI)  || !mem_valid);
    assign mem_ready = !reset && !freeze && ((state_q == MEM_PRI) || !wb_valid);
    assign mem_pri   = (state_q == MEM_PRI);

    assign wb_hs     = wb_valid  && wb_ready;
    assign mem_hs    = mem_valid && mem_ready;
    assign hs        = wb_hs || mem_hs;

    assign mem_stall = mem_valid && !mem_ready && !freeze;
    assign wait_inc  = wait_q + CNT_W'(1);
    assign flip      = (state_q == WB_PRI) && mem_stall && (wait_inc == CNT_W'(MAX_WAIT));

    // Pick the payload of whichever requester handshakes; the readies make them exclusive.
    always_comb begin
        sel_rd   = wb_rd;
        sel_data = wb_data;
        if (mem_hs) begin
            sel_rd   = mem_rd;
            sel_data = mem_data;
        end
    end

    // Priority FSM and starvation wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WB_PRI;
            wait_q  <= '0;
        end else begin
            if (mem_hs) begin
                wait_q <= '0;
            end else if (mem_stall) begin
                wait_q <= wait_inc;
            end
            case (state_q)
                WB_PRI:  if (flip)   state_q <= MEM_PRI;
                MEM_PRI: if (mem_hs) state_q <= WB_PRI;
                default:             state_q <= WB_PRI;
            endcase
        end
    end

    // Registered write port; x0 handshakes complete but leave rd/data untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= hs && (sel_rd != '0);
            if (hs && (sel_rd != '0)) begin
                rf_rd_q    <= sel_rd;
                rf_wdata_q <= sel_data;
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;

`ifdef RFARB_STATS_EN
    logic [STAT_W-1:0] conflict_q;

    // Saturating count of cycles where both requesters are valid, independent of freeze.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= '0;
        end else if (wb_valid && mem_valid && (conflict_q != {STAT_W{1'b1}})) begin
            conflict_q <= conflict_q + STAT_W'(1);
        end
    end

    assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: directed cycles push the expected write-port
// contents; a monitor pops and compares them one cycle later.
module tb_rf_write_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          freeze = 1'b0;
    logic          wb_valid = 1'b0;
    logic [AW-1:0] wb_rd = '0;
    logic [DW-1:0] wb_data = '0;
    logic          wb_ready;
    logic          mem_valid = 1'b0;
    logic [AW-1:0] mem_rd = '0;
    logic [DW-1:0] mem_data = '0;
    logic          mem_ready;
    logic          rf_we;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_wdata;
    logic          mem_pri;
`ifdef RFARB_STATS_EN
    logic [15:0]   conflict_cnt;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb_q[$];
    logic [AW-1:0] m_rd = '0;
    logic [DW-1:0] m_data = '0;

    rf_write_arbiter #(.MAX_WAIT(3), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .freeze    (freeze),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_ready  (wb_ready),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
        .mem_pri   (mem_pri)
`ifdef RFARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
        end
    endtask

    // One directed cycle: drive at negedge, check readies/state, push the expected write.
    // grant: 0 none, 1 wb, 2 mem.
    task automatic step(input logic r, input logic f,
                        input logic wv, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                        input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                        input logic e_wbr, input logic e_mr, input logic e_mp,
                        input int grant);
        exp_t e;
        @(negedge clk);
        reset = r; freeze = f;
        wb_valid = wv; wb_rd = wr; wb_data = wd;
        mem_valid = mv; mem_rd = mr; mem_data = md;
        #1;
        check("wb_ready", 32'(wb_ready), 32'(e_wbr));
        check("mem_ready", 32'(mem_ready), 32'(e_mr));
        check("mem_pri", 32'(mem_pri), 32'(e_mp));
        e.we = 1'b0;
        if (r) begin
            m_rd = '0;
            m_data = '0;
        end else if (grant == 1 && wr != '0) begin
            e.we = 1'b1; m_rd = wr; m_data = wd;
        end else if (grant == 2 && mr != '0) begin
            e.we = 1'b1; m_rd = mr; m_data = md;
        end
        e.rd = m_rd;
        e.data = m_data;
        sb_q.push_back(e);
    endtask

    // Monitor: after each rising edge compare the write port against the next expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("rf_we", 32'(rf_we), 32'(e.we));
                check("rf_rd", 32'(rf_rd), 32'(e.rd));
                check("rf_wdata", rf_wdata, e.data);
            end
        end
    end

    initial begin
        // reset and idle
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        // single write
        step(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        // starvation guard: three stalls, flip, mem granted, wb resumes
        step(0, 0, 1, 1, 32'h11, 1, 9, 32'hAAAA0009, 1, 0, 0, 1);
        step(0, 0, 1, 2, 32'h22, 1, 9, 32'hAAAA0009, 1, 0, 0, 1);
        step(0, 0, 1, 3, 32'h33, 1, 9, 32'hAAAA0009, 1, 0, 0, 1);
        step(0, 0, 1, 4, 32'h44, 1, 9, 32'hAAAA0009, 0, 1, 1, 2);
        step(0, 0, 1, 4, 32'h44, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 5, 32'h55, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 6, 32'h66, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 7, 32'h77, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        // x0 write is accepted and dropped; rd/data hold
        step(0, 0, 0, 0, 0, 1, 0, 32'h1234, 1, 1, 0, 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        // MEM_PRI with mem withdrawn still grants wb and keeps MEM_PRI
        step(0, 0, 1, 10, 32'hA0, 1, 11, 32'hB0, 1, 0, 0, 1);
        step(0, 0, 1, 12, 32'hA2, 1, 11, 32'hB0, 1, 0, 0, 1);
        step(0, 0, 1, 13, 32'hA3, 1, 11, 32'hB0, 1, 0, 0, 1);
        step(0, 0, 1, 14, 32'hA4, 0, 0, 0, 1, 1, 1, 1);
        step(0, 0, 1, 15, 32'hA5, 1, 11, 32'hB0, 0, 1, 1, 2);
        step(0, 0, 1, 15, 32'hA5, 0, 0, 0, 1, 0, 0, 1);
        // freeze holds wait counter: flip occurs only two grants after release
        step(0, 0, 1, 16, 32'hC0, 1, 17, 32'hD0, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++)
            step(0, 1, 1, 18, 32'hC8, 1, 17, 32'hD0, 0, 0, 0, 0);
        step(0, 0, 1, 18, 32'hC8, 1, 17, 32'hD0, 1, 0, 0, 1);
        step(0, 0, 1, 19, 32'hC9, 1, 17, 32'hD0, 1, 0, 0, 1);
        step(0, 0, 1, 20, 32'hCA, 1, 17, 32'hD0, 0, 1, 1, 2);
        step(0, 0, 1, 20, 32'hCA, 0, 0, 0, 1, 0, 0, 1);
        // reset while in MEM_PRI with requests pending
        step(0, 0, 1, 21, 32'hE1, 1, 24, 32'hF4, 1, 0, 0, 1);
        step(0, 0, 1, 22, 32'hE2, 1, 24, 32'hF4, 1, 0, 0, 1);
        step(0, 0, 1, 23, 32'hE3, 1, 24, 32'hF4, 1, 0, 0, 1);
        step(1, 0, 1, 25, 32'hE5, 1, 24, 32'hF4, 0, 0, 1, 0);
        step(0, 0, 1, 25, 32'hE5, 1, 24, 32'hF4, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
`ifdef RFARB_STATS_EN
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (10) begin
            @(negedge clk);
            reset = 0; freeze = 1; wb_valid = 1; mem_valid = 1;
        end
        @(negedge clk);
        wb_valid = 0; mem_valid = 0; freeze = 0;
        #1 check("conflict_cnt_10", 32'(conflict_cnt), 32'd10);
        repeat (65524) begin
            @(negedge clk);
            freeze = 1; wb_valid = 1; mem_valid = 1;
        end
        @(negedge clk);
        wb_valid = 0; mem_valid = 0; freeze = 0;
        #1 check("conflict_cnt_fffe", 32'(conflict_cnt), 32'hFFFE);
        repeat (3) begin
            @(negedge clk);
            freeze = 1; wb_valid = 1; mem_valid = 1;
        end
        @(negedge clk);
        wb_valid = 0; mem_valid = 0; freeze = 0;
        #1 check("conflict_cnt_sat", 32'(conflict_cnt), 32'hFFFF);
`endif
        repeat (3) @(negedge clk);
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
